// File: rtl/bus_io_controller.sv
// bus_io_controller: decodes CPU accesses to RAM, ROM or the on-chip I/O page
// and returns the read data one cycle later. The I/O page holds an output port,
// a synchronized input port, a TX byte FIFO and a one-byte RX holding register.
module bus_io_controller #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  IO_PAGE     = 8'hD0,
  parameter logic [7:0]  ROM_BASE_HI = 8'hE0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        READ_write,
  input  logic [15:0] address_in,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        ram_cs,
  output logic        rom_cs,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  output logic [7:0]  port_out,
  input  logic [7:0]  port_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    REG_PORT_OUT = 4'h0,
    REG_PORT_IN  = 4'h1,
    REG_TX_DATA  = 4'h2,
    REG_STATUS   = 4'h3,
    REG_RX_DATA  = 4'h4
  } io_reg_e;

  // Decode and edge-detect signals
  logic        io_hit;
  io_reg_e     io_off;
  logic        io_rd;
  logic        io_wr;
  logic        new_access;
  logic [15:0] prev_addr;
  logic        prev_rw;
  logic        prev_valid;

  // TX FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop_tx;
  logic             ovf_set;
  logic             tx_ovf;

  // RX holding register and input synchronizer
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ovr;
  logic       rx_pop;
  logic       rx_ovr_set;
  logic       status_wr;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] status;
  logic [7:0] read_mux;

  assign ram_cs = !address_in[15];
  assign rom_cs = (address_in >= {ROM_BASE_HI, 8'h00});
  assign io_hit = (address_in[15:8] == IO_PAGE);
  // Bits [7:4] are deliberately ignored so the 16 registers alias across the page.
  assign io_off = io_reg_e'(address_in[3:0]);
  assign io_rd  = io_hit && !READ_write;
  assign io_wr  = io_hit && READ_write;

  // A new access starts whenever address or direction differs from last cycle.
  assign new_access = !prev_valid || (address_in != prev_addr) || (READ_write != prev_rw);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop_tx     = tx_ready && !fifo_empty;
  assign push_req   = io_wr && (io_off == REG_TX_DATA) && new_access;
  assign push_ok    = push_req && (!fifo_full || pop_tx);
  assign ovf_set    = push_req && fifo_full && !pop_tx;
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : mem[rd_ptr];

  assign rx_pop     = io_rd && (io_off == REG_RX_DATA) && new_access;
  assign rx_ovr_set = rx_strobe && rx_valid && !rx_pop;
  assign status_wr  = io_wr && (io_off == REG_STATUS);
  assign status     = {rx_valid, 3'b000, rx_ovr, tx_ovf, fifo_full, fifo_empty};

  // Select the read source for the current address.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    read_mux = 8'h00;
    if (ram_cs) begin
      read_mux = ram_rdata;
    end else if (rom_cs) begin
      read_mux = rom_rdata;
    end else if (io_hit) begin
      case (io_off)
        REG_PORT_OUT: read_mux = port_out;
        REG_PORT_IN:  read_mux = sync2;
        REG_STATUS:   read_mux = status;
        REG_RX_DATA:  read_mux = rx_byte;
        default:      read_mux = 8'h00;
      endcase
    end
  end

  // Registered read data, previous-access tracker, output port and synchronizer.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      // NOTE: state updates use non-blocking assignments so all flops sample together.
      cpu_rdata  <= 8'h00;
      prev_addr  <= 16'h0000;
      prev_rw    <= 1'b0;
      prev_valid <= 1'b0;
      port_out   <= 8'h00;
      sync1      <= 8'h00;
      sync2      <= 8'h00;
    end else begin
      if (!READ_write) cpu_rdata <= read_mux;
      prev_addr  <= address_in;
      prev_rw    <= READ_write;
      prev_valid <= 1'b1;
      if (io_wr && (io_off == REG_PORT_OUT)) port_out <= cpu_wdata;
      sync1 <= port_in;
      sync2 <= sync1;
    end
  end

  // FIFO storage: contents are only observable through count, so no reset.
  always_ff @(posedge clk_in) begin
    // NOTE: the storage array is left unreset; empty entries are never read out.
    if (push_ok) mem[wr_ptr] <= cpu_wdata;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_tx)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_tx})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set)                        tx_ovf <= 1'b1;
      else if (status_wr && cpu_wdata[2]) tx_ovf <= 1'b0;
    end
  end

  // RX holding register with valid and sticky overrun flags.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      if (rx_strobe) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_ovr_set)                     rx_ovr <= 1'b1;
      else if (status_wr && cpu_wdata[3]) rx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_io_controller.sv
// Bench for bus_io_controller: a queue-based model of the bus map checked every
// cycle, plus directed accesses with literal expected values.
module tb_bus_io_controller;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        READ_write = 1'b0;
  logic [15:0] address_in = 16'h9000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        ram_cs;
  logic        rom_cs;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  rom_rdata = 8'h00;
  logic [7:0]  port_out;
  logic [7:0]  port_in = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_strobe = 1'b0;

  int checks = 0;
  int failures = 0;

  bus_io_controller #(.FIFO_DEPTH(16), .IO_PAGE(8'hD0), .ROM_BASE_HI(8'hE0)) dut (
    .clk_in(clk_in), .reset(reset), .READ_write(READ_write), .address_in(address_in),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ram_cs(ram_cs), .rom_cs(rom_cs),
    .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .port_out(port_out), .port_in(port_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  always #5 clk_in = ~clk_in;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];
  logic [7:0]  pin_hist[$] = '{8'h00, 8'h00};
  logic [7:0]  m_rdata = 8'h00;
  logic [7:0]  m_port_out = 8'h00;
  logic [7:0]  m_rx_byte = 8'h00;
  bit          m_rx_valid = 0;
  bit          m_rx_ovr = 0;
  bit          m_tx_ovf = 0;
  bit          m_have_prev = 0;
  logic [15:0] m_prev_a = 16'h0000;
  logic        m_prev_rw = 1'b0;

  function automatic logic [7:0] m_status();
    return {m_rx_valid, 3'b000, m_rx_ovr, m_tx_ovf, q.size() == 16, q.size() == 0};
  endfunction

  task automatic model_reset();
    q.delete();
    pin_hist = '{8'h00, 8'h00};
    m_rdata = 8'h00; m_port_out = 8'h00; m_rx_byte = 8'h00;
    m_rx_valid = 0; m_rx_ovr = 0; m_tx_ovf = 0; m_have_prev = 0;
  endtask

  task automatic model_step();
    logic [7:0] rd;
    logic [3:0] off;
    bit io, newacc, pop_tx, push, ovf_set, rx_pop, ovr_set, stw;
    io     = (address_in[15:8] == 8'hD0);
    off    = address_in[3:0];
    newacc = !m_have_prev || (address_in != m_prev_a) || (READ_write != m_prev_rw);
    rd = 8'h00;
    if (address_in < 16'h8000)       rd = ram_rdata;
    else if (address_in >= 16'hE000) rd = rom_rdata;
    else if (io) begin
      case (off)
        4'h0:    rd = m_port_out;
        4'h1:    rd = pin_hist[0];
        4'h3:    rd = m_status();
        4'h4:    rd = m_rx_byte;
        default: rd = 8'h00;
      endcase
    end
    if (!READ_write) m_rdata = rd;
    stw     = io && READ_write && (off == 4'h3);
    pop_tx  = tx_ready && (q.size() > 0);
    push    = io && READ_write && (off == 4'h2) && newacc;
    ovf_set = push && (q.size() == 16) && !pop_tx;
    if (pop_tx) void'(q.pop_front());
    if (push && !ovf_set) q.push_back(cpu_wdata);
    if (ovf_set) m_tx_ovf = 1;
    else if (stw && cpu_wdata[2]) m_tx_ovf = 0;
    rx_pop  = io && !READ_write && (off == 4'h4) && newacc;
    ovr_set = rx_strobe && m_rx_valid && !rx_pop;
    if (rx_strobe) begin
      m_rx_byte = rx_data; m_rx_valid = 1;
    end else if (rx_pop) m_rx_valid = 0;
    if (ovr_set) m_rx_ovr = 1;
    else if (stw && cpu_wdata[3]) m_rx_ovr = 0;
    if (io && READ_write && (off == 4'h0)) m_port_out = cpu_wdata;
    pin_hist.push_back(port_in);
    void'(pin_hist.pop_front());
    m_have_prev = 1; m_prev_a = address_in; m_prev_rw = READ_write;
  endtask

  // Advance the model on every clock edge, or clear it on reset.
  always @(posedge clk_in or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge clk_in) begin
    if (!reset) begin
      check8("cyc_cpu_rdata", cpu_rdata, m_rdata);
      check8("cyc_port_out", port_out, m_port_out);
      check1("cyc_tx_valid", tx_valid, q.size() > 0);
      check8("cyc_tx_data", tx_data, (q.size() > 0) ? q[0] : 8'h00);
      check1("cyc_ram_cs", ram_cs, address_in < 16'h8000);
      check1("cyc_rom_cs", rom_cs, address_in >= 16'hE000);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d, input int n);
    address_in = a; READ_write = rw; cpu_wdata = d;
    tick(n);
  endtask

  task automatic idle(input int n);
    bus(16'h9000, 1'b0, 8'h00, n);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    bus(a, 1'b0, 8'h00, 1);
    check8(name, cpu_rdata, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b1, d, 1);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_strobe = 1'b1;
    tick(1);
    rx_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    check8("reset_cpu_rdata", cpu_rdata, 8'h00);
    check8("reset_port_out", port_out, 8'h00);
    check1("reset_tx_valid", tx_valid, 1'b0);
    check8("reset_tx_data", tx_data, 8'h00);

    // RAM read, one-cycle latency
    ram_rdata = 8'h5A; address_in = 16'h0000; READ_write = 1'b0;
    #1;
    check1("ram_cs_sel", ram_cs, 1'b1);
    check1("rom_cs_nosel", rom_cs, 1'b0);
    tick(1);
    check8("ram_read", cpu_rdata, 8'h5A);

    // Output port with alias, synchronized input port
    wr(16'hD000, 8'hA5);
    rd(16'hD010, 8'hA5, "port_out_alias");
    check8("port_out_reg", port_out, 8'hA5);
    port_in = 8'h3C;
    idle(3);
    rd(16'hD001, 8'h3C, "port_in_sync");

    // ROM, unmapped, unused I/O offsets
    rom_rdata = 8'hC3; address_in = 16'hF000;
    #1;
    check1("rom_cs_sel", rom_cs, 1'b1);
    tick(1);
    check8("rom_read", cpu_rdata, 8'hC3);
    rd(16'hA000, 8'h00, "unmapped_read");
    rd(16'hD007, 8'h00, "io_unused_read");
    rd(16'hD002, 8'h00, "tx_data_read");

    // TX FIFO fill past full with held writes
    tx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      bus(16'hD002, 1'b1, 8'(i), 3);
      idle(1);
    end
    rd(16'hD003, 8'h06, "status_full_ovf");
    wr(16'hD003, 8'h04);
    rd(16'hD003, 8'h02, "status_ovf_cleared");
    tx_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_in);
      check1("stream_valid", tx_valid, 1'b1);
      check8("stream_data", tx_data, 8'(k));
    end
    @(negedge clk_in);
    check1("stream_drained", tx_valid, 1'b0);
    tick(1);
    rd(16'hD003, 8'h01, "status_empty");

    // RX overrun then pop
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd(16'hD003, 8'h89, "status_rx_ovr");
    rd(16'hD004, 8'h22, "rx_pop_last");
    rd(16'hD003, 8'h09, "status_after_pop");
    wr(16'hD003, 8'h08);
    rd(16'hD003, 8'h01, "status_ovr_cleared");

    // Strobe in the same cycle as a pop
    rx_pulse(8'h22);
    rx_data = 8'h33; rx_strobe = 1'b1;
    bus(16'hD004, 1'b0, 8'h00, 1);
    rx_strobe = 1'b0;
    check8("pop_with_strobe", cpu_rdata, 8'h22);
    rd(16'hD003, 8'h81, "status_valid_kept");
    rd(16'hD004, 8'h33, "rx_next_pop");
    rd(16'hD003, 8'h01, "status_rx_empty");

    // Overrun set and CPU clear in the same cycle: set wins
    rx_pulse(8'h66);
    rx_data = 8'h77; rx_strobe = 1'b1;
    wr(16'hD003, 8'h08);
    rx_strobe = 1'b0;
    rd(16'hD003, 8'h89, "set_wins_clear");
    rd(16'hD004, 8'h77, "rx_pop_77");
    wr(16'hD003, 8'h08);
    rd(16'hD003, 8'h01, "status_clean");

    // Asynchronous reset with FIFO entries and a pending RX byte
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr(16'hD002, 8'(8'h40 + i));
      idle(1);
    end
    rx_pulse(8'h44);
    check1("pre_reset_valid", tx_valid, 1'b1);
    check8("pre_reset_head", tx_data, 8'h41);
    #2;
    reset = 1'b1;
    #1;
    check1("async_tx_valid", tx_valid, 1'b0);
    check8("async_tx_data", tx_data, 8'h00);
    check8("async_cpu_rdata", cpu_rdata, 8'h00);
    check8("async_port_out", port_out, 8'h00);
    tick(1);
    reset = 1'b0;
    rd(16'hD003, 8'h01, "status_after_reset");
    rd(16'hD004, 8'h00, "rx_byte_after_reset");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
